// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_pipe
// Brief    : Instruction decode stage with a register file, load-use hazard
//            detection, J/JAL redirect and the ID/EX pipeline register.
// Revision : 1.0
// ============================================================================
module decode_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [31:0]       instr_in,
    input  logic              instr_valid,
    input  logic [31:0]       pc4_in,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_memread,
    input  logic [AW-1:0]     ex_rt,
    output logic              stall,
    output logic              jump_taken,
    output logic [31:0]       jump_target,
    output logic              idex_valid,
    output logic [5:0]        idex_op,
    output logic [5:0]        idex_funct,
    output logic [4:0]        idex_shamt,
    output logic [AW-1:0]     idex_rs,
    output logic [AW-1:0]     idex_rt,
    output logic [AW-1:0]     idex_rd,
    output logic [DATA_W-1:0] idex_rs_data,
    output logic [DATA_W-1:0] idex_rt_data,
    output logic [DATA_W-1:0] idex_imm,
    output logic [15:0]       stall_count
);

    logic [DATA_W-1:0] r_rf [NREGS];

    logic [5:0]        w_op;
    logic [AW-1:0]     w_rs;
    logic [AW-1:0]     w_rt;
    logic [AW-1:0]     w_rd;
    logic              w_is_jump;
    logic              w_rs_src;
    logic              w_rt_src;
    logic              w_hazard;
    logic              w_bubble;
    logic              w_rf_wr;
    logic              w_zext;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic [DATA_W-1:0] w_imm;

    assign w_op = instr_in[31:26];
    assign w_rs = AW'(instr_in[25:21]);
    assign w_rt = AW'(instr_in[20:16]);
    assign w_rd = AW'(instr_in[15:11]);

    assign w_is_jump = (w_op == 6'h02) || (w_op == 6'h03);
    assign w_rs_src  = !w_is_jump;
    assign w_rt_src  = (w_op == 6'h00) || (w_op == 6'h04) ||
                       (w_op == 6'h05) || (w_op == 6'h2B);

    assign w_hazard = instr_valid && ex_memread && (ex_rt != '0) &&
                      ((w_rs_src && (ex_rt == w_rs)) || (w_rt_src && (ex_rt == w_rt)));

    // Reset and flush both dominate the hazard and the redirect.
    assign stall       = !Rst && !flush && w_hazard;
    assign jump_taken  = !Rst && !flush && instr_valid && !w_hazard && w_is_jump;
    assign jump_target = jump_taken ? {pc4_in[31:28], instr_in[25:0], 2'b00} : 32'h0;

    assign w_bubble = stall || flush || !instr_valid;
    assign w_rf_wr  = wb_we && (wb_addr != '0);

    always_comb begin
        w_rs_data = r_rf[w_rs];
        w_rt_data = r_rf[w_rt];
        if ((BYPASS != 0) && w_rf_wr && (wb_addr == w_rs)) w_rs_data = wb_data;
        if ((BYPASS != 0) && w_rf_wr && (wb_addr == w_rt)) w_rt_data = wb_data;
        if (w_rs == '0) w_rs_data = '0;
        if (w_rt == '0) w_rt_data = '0;
    end

    assign w_zext = (w_op == 6'h0C) || (w_op == 6'h0D) || (w_op == 6'h0E);
    assign w_imm  = w_zext ? {{(DATA_W-16){1'b0}}, instr_in[15:0]}
                           : {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else if (w_rf_wr) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || w_bubble) begin
            idex_valid   <= 1'b0;
            idex_op      <= '0;
            idex_funct   <= '0;
            idex_shamt   <= '0;
            idex_rs      <= '0;
            idex_rt      <= '0;
            idex_rd      <= '0;
            idex_rs_data <= '0;
            idex_rt_data <= '0;
            idex_imm     <= '0;
        end else begin
            idex_valid   <= 1'b1;
            idex_op      <= w_op;
            idex_funct   <= instr_in[5:0];
            idex_shamt   <= instr_in[10:6];
            idex_rs      <= w_rs;
            idex_rt      <= w_rt;
            idex_rt_data <= w_rt_data;
            idex_imm     <= w_imm;
            // JAL links through rd=31 and carries the return address as rs data.
            if (w_op == 6'h03) begin
                idex_rd      <= AW'(5'd31);
                idex_rs_data <= DATA_W'(pc4_in);
            end else begin
                idex_rd      <= w_rd;
                idex_rs_data <= w_rs_data;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_pipe
// Brief    : Directed and random stimulus for decode_stage_pipe against a
//            behavioural decode model.
// Revision : 1.0
// ============================================================================
module tb_decode_stage_pipe;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic [31:0] pc4_in;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        stall;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic        idex_valid;
    logic [5:0]  idex_op;
    logic [5:0]  idex_funct;
    logic [4:0]  idex_shamt;
    logic [4:0]  idex_rs;
    logic [4:0]  idex_rt;
    logic [4:0]  idex_rd;
    logic [31:0] idex_rs_data;
    logic [31:0] idex_rt_data;
    logic [31:0] idex_imm;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_rf [32];
    int          m_cnt;
    logic [5:0]  oplist [11];

    decode_stage_pipe #(.DATA_W(32), .NREGS(32), .BYPASS(1)) dut (
        .Clk(Clk), .Rst(Rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .pc4_in(pc4_in), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .stall(stall), .jump_taken(jump_taken), .jump_target(jump_target),
        .idex_valid(idex_valid), .idex_op(idex_op), .idex_funct(idex_funct),
        .idex_shamt(idex_shamt), .idex_rs(idex_rs), .idex_rt(idex_rt),
        .idex_rd(idex_rd), .idex_rs_data(idex_rs_data),
        .idex_rt_data(idex_rt_data), .idex_imm(idex_imm),
        .stall_count(stall_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdval(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_we && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    // One clock: check combinational outputs mid-cycle, then ID/EX after the edge.
    task automatic cycle();
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic        uses_rs, uses_rt, e_stall, e_jump, e_valid;
        logic [31:0] e_target, e_rsd, e_rtd, e_imm;
        logic [5:0]  e_op, e_funct;
        logic [4:0]  e_shamt, e_rs, e_rt, e_rd;
        op = instr_in[31:26];
        rs = instr_in[25:21];
        rt = instr_in[20:16];
        uses_rs = !(op == 6'h02 || op == 6'h03);
        uses_rt = (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B);
        e_stall = !Rst && instr_valid && !flush && ex_memread && ex_rt != 5'd0 &&
                  ((uses_rs && ex_rt == rs) || (uses_rt && ex_rt == rt));
        e_jump  = !Rst && instr_valid && !flush && !e_stall && (op == 6'h02 || op == 6'h03);
        e_target = e_jump ? {pc4_in[31:28], instr_in[25:0], 2'b00} : 32'h0;
        e_valid = !Rst && instr_valid && !flush && !e_stall;
        e_op = 0; e_funct = 0; e_shamt = 0; e_rs = 0; e_rt = 0; e_rd = 0;
        e_rsd = 0; e_rtd = 0; e_imm = 0;
        if (e_valid) begin
            e_op = op; e_funct = instr_in[5:0]; e_shamt = instr_in[10:6];
            e_rs = rs; e_rt = rt; e_rd = instr_in[15:11];
            e_rsd = rdval(rs); e_rtd = rdval(rt);
            if (op == 6'h0C || op == 6'h0D || op == 6'h0E) e_imm = {16'h0, instr_in[15:0]};
            else e_imm = {{16{instr_in[15]}}, instr_in[15:0]};
            if (op == 6'h03) begin
                e_rd  = 5'd31;
                e_rsd = pc4_in;
            end
        end
        #4;
        chk("stall", stall, e_stall);
        chk("jump_taken", jump_taken, e_jump);
        chk("jump_target", jump_target, e_target);
        @(posedge Clk);
        if (Rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
            m_cnt = 0;
        end else begin
            if (wb_we && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
            if (e_stall && m_cnt < 65535) m_cnt++;
        end
        #1;
        chk("idex_valid", idex_valid, e_valid);
        chk("idex_op", idex_op, e_op);
        chk("idex_funct", idex_funct, e_funct);
        chk("idex_shamt", idex_shamt, e_shamt);
        chk("idex_rs", idex_rs, e_rs);
        chk("idex_rt", idex_rt, e_rt);
        chk("idex_rd", idex_rd, e_rd);
        chk("idex_rs_data", idex_rs_data, e_rsd);
        chk("idex_rt_data", idex_rt_data, e_rtd);
        chk("idex_imm", idex_imm, e_imm);
        chk("stall_count", stall_count, m_cnt[15:0]);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        w[31:26] = oplist[$urandom_range(0, 10)];
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        oplist[0] = 6'h00; oplist[1] = 6'h02; oplist[2]  = 6'h03; oplist[3] = 6'h04;
        oplist[4] = 6'h05; oplist[5] = 6'h0C; oplist[6]  = 6'h0D; oplist[7] = 6'h0E;
        oplist[8] = 6'h23; oplist[9] = 6'h2B; oplist[10] = 6'h08;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_cnt = 0;

        // Reset with a hazard, a jump candidate and a writeback all present.
        Rst = 1; instr_valid = 1; flush = 0; pc4_in = 32'h1000_0004;
        instr_in = {6'h00, 5'd7, 5'd4, 5'd2, 5'd0, 6'h22};
        wb_we = 1; wb_addr = 5'd9; wb_data = 32'hDEAD_BEEF;
        ex_memread = 1; ex_rt = 5'd7;
        cycle();
        instr_in = 32'h0800_0040;
        cycle();

        // Writeback r5 while ADD r3,r5,r0 reads it.
        Rst = 0; ex_memread = 0; ex_rt = 0;
        wb_we = 1; wb_addr = 5'd5; wb_data = 32'h1234;
        instr_in = {6'h00, 5'd5, 5'd0, 5'd3, 5'd0, 6'h20};
        cycle();
        chk("bypass_rs_data", idex_rs_data, 32'h1234);

        // Writes during reset must not have landed in r9.
        wb_we = 0; instr_in = {6'h00, 5'd9, 5'd5, 5'd3, 5'd0, 6'h20};
        cycle();
        chk("r9_after_reset", idex_rs_data, 32'h0);

        // Load-use: SUB r2,r7,r4 behind a load to r7.
        ex_memread = 1; ex_rt = 5'd7;
        instr_in = {6'h00, 5'd7, 5'd4, 5'd2, 5'd0, 6'h22};
        cycle();
        chk("loaduse_count", stall_count, 16'd1);
        ex_memread = 0;
        cycle();
        chk("loaduse_release", idex_valid, 1'b1);

        // JAL redirect and link.
        pc4_in = 32'h4000_0010; instr_in = 32'h0C00_0100;
        #4;
        chk("jal_target_const", jump_target, 32'h4000_0400);
        #2;
        cycle();
        chk("jal_rd_const", idex_rd, 5'd31);
        chk("jal_link_const", idex_rs_data, 32'h4000_0010);

        // Immediate extension: ORI zero-extends, LW sign-extends.
        instr_in = {6'h0D, 5'd1, 5'd2, 16'h8001};
        cycle();
        chk("ori_imm_const", idex_imm, 32'h0000_8001);
        instr_in = {6'h23, 5'd1, 5'd2, 16'h8001};
        cycle();
        chk("lw_imm_const", idex_imm, 32'hFFFF_8001);

        // Hazard and flush together; write to r0 is discarded.
        ex_memread = 1; ex_rt = 5'd7; flush = 1;
        instr_in = {6'h00, 5'd7, 5'd4, 5'd2, 5'd0, 6'h22};
        wb_we = 1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        cycle();
        flush = 0; ex_memread = 0;
        instr_in = {6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20};
        cycle();
        wb_we = 0;
        cycle();
        chk("r0_reads_zero", idex_rs_data, 32'h0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            instr_in    = rand_instr();
            instr_valid = ($urandom_range(0, 7) != 0);
            flush       = ($urandom_range(0, 7) == 0);
            pc4_in      = $urandom;
            wb_we       = $urandom_range(0, 1);
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            ex_memread  = ($urandom_range(0, 2) == 0);
            ex_rt       = 5'($urandom_range(0, 7));
            Rst         = ($urandom_range(0, 99) == 0);
            cycle();
        end

        // Long hazard to saturate the stall counter.
        Rst = 0; instr_valid = 1; flush = 0; wb_we = 0;
        ex_memread = 1; ex_rt = 5'd7;
        instr_in = {6'h00, 5'd7, 5'd4, 5'd2, 5'd0, 6'h22};
        for (int n = 0; n < 70000; n++) cycle();
        chk("stall_count_sat", stall_count, 16'hFFFF);

        // Reset mid-stall, then decode normally.
        Rst = 1;
        cycle();
        chk("reset_count", stall_count, 16'h0);
        chk("reset_valid", idex_valid, 1'b0);
        Rst = 0; ex_memread = 0;
        cycle();
        chk("post_reset_valid", idex_valid, 1'b1);
        for (int n = 0; n < 20; n++) begin
            instr_in = rand_instr(); instr_valid = 1; flush = 0;
            wb_we = $urandom_range(0, 1); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
